// File: rtl/gc_pkg.sv
// Shared types and header-word layout for the garbled-circuit label packer.
package gc_pkg;

    // Record kind carried in the two top bits of every header word.
    typedef enum logic [1:0] {
        LABEL = 2'b00,
        KEY   = 2'b01,
        TABLE = 2'b10,
        MASK  = 2'b11
    } rec_kind_e;

    localparam int WORD_W       = 32;
    localparam int HDR_KIND_MSB = 31;
    localparam int HDR_KIND_LSB = 30;
    localparam int HDR_CID_MSB  = 29;
    localparam int HDR_CID_LSB  = 16;
    localparam int HDR_IDX_MSB  = 15;
    localparam int HDR_IDX_LSB  = 0;
    localparam int HDR_CID_W    = HDR_CID_MSB - HDR_CID_LSB + 1;
    localparam int HDR_IDX_W    = HDR_IDX_MSB - HDR_IDX_LSB + 1;

    // Pack kind, circuit cycle and wire index into one host header word.
    function automatic logic [WORD_W-1:0] gc_build_header(
        input rec_kind_e             kind,
        input logic [HDR_CID_W-1:0] cid,
        input logic [HDR_IDX_W-1:0] index
    );
        logic [WORD_W-1:0] hdr;
        hdr                            = 32'h0000_0000;
        hdr[HDR_KIND_MSB:HDR_KIND_LSB] = kind;
        hdr[HDR_CID_MSB:HDR_CID_LSB]   = cid;
        hdr[HDR_IDX_MSB:HDR_IDX_LSB]   = index;
        return hdr;
    endfunction

endpackage

// File: rtl/gc_label_packer_if.sv
// 32-bit valid/ready host stream carrying serialised label records.
interface gc_label_packer_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/gc_dual_push_fifo.sv
// Record FIFO with two write ports (port 1 only used together with port 0),
// one first-word-fall-through read port and an occupancy count.
module gc_dual_push_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr0_en,
    input  logic [W-1:0]  wr0_data,
    input  logic          wr1_en,
    input  logic [W-1:0]  wr1_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_n_wr;
    logic [CW-1:0] w_n_rd;

    // Number of entries written and read this cycle.
    always_comb begin
        w_n_wr = {CW{1'b0}};
        w_n_rd = {CW{1'b0}};
        if (wr0_en && wr1_en) begin
            w_n_wr = CW'(2);
        end else if (wr0_en) begin
            w_n_wr = CW'(1);
        end else begin
            w_n_wr = {CW{1'b0}};
        end
        if (rd_en && (r_count != {CW{1'b0}})) begin
            w_n_rd = CW'(1);
        end else begin
            w_n_rd = {CW{1'b0}};
        end
    end

    // Storage: slot0 lands at the write pointer, slot1 right behind it.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wr0_en) begin
                r_mem[r_wptr] <= wr0_data;
            end
            if (wr0_en && wr1_en) begin
                r_mem[r_wptr + AW'(1)] <= wr1_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (flush) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_wptr  <= r_wptr + w_n_wr[AW-1:0];
            r_rptr  <= r_rptr + w_n_rd[AW-1:0];
            r_count <= r_count + w_n_wr - w_n_rd;
        end
    end

    assign rd_data = r_mem[r_rptr];
    assign empty   = (r_count == {CW{1'b0}});
    assign count   = r_count;

endmodule

// File: rtl/gc_label_packer.sv
// Captures GarbledCircuit tag/index/data slots into a record FIFO and
// serialises each record as one header word plus K/32 data words.
module gc_label_packer
    import gc_pkg::*;
#(
    parameter int S     = 12,
    parameter int K     = 128,
    parameter int CC    = 1,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                tag_t1,
    input  logic [S-1:0]              cid,
    input  logic [S-1:0]              index0_t1,
    input  logic [S-1:0]              index1_t1,
    input  logic [K-1:0]              data0_t1,
    input  logic [K-1:0]              data1_t1,
    gc_label_packer_if.master         host,
    output logic                      overflow,
    output logic                      done
);
    localparam int NW    = K / WORD_W;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int FCW   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NW - 1);
    localparam logic [FCW-1:0]   DEPTH_CNT = FCW'(DEPTH);
    localparam logic [S-1:0]     CID_END   = S'(CC);

    // Record widths depend on S and K, so the record type lives here.
    typedef struct packed {
        rec_kind_e    kind;
        logic [S-1:0] cid;
        logic [S-1:0] index;
        logic [K-1:0] data;
    } gc_rec_t;

    typedef enum logic [1:0] {CTL_IDLE, CTL_RUN, CTL_DRAIN, CTL_DONE} ctl_state_e;
    typedef enum logic [1:0] {SER_IDLE, SER_HDR, SER_DATA} ser_state_e;

    ctl_state_e        r_ctl_state;
    ser_state_e        r_ser_state;
    logic              r_overflow;
    logic              r_done;
    logic [31:0]       r_out_data;
    logic              r_out_valid;
    logic [K-1:0]      r_shift;
    logic [CNT_W-1:0]  r_word_cnt;

    logic              w_slot0_v;
    logic              w_slot1_v;
    rec_kind_e         w_kind;
    logic [S-1:0]      w_idx0;
    logic [S-1:0]      w_idx1;
    gc_rec_t           w_rec0;
    gc_rec_t           w_rec1;
    gc_rec_t           w_wr0_rec;
    gc_rec_t           w_rd_rec;
    logic [FCW-1:0]    w_need;
    logic [FCW-1:0]    w_free;
    logic [FCW-1:0]    w_fifo_count;
    logic              w_fifo_empty;
    logic              w_capture;
    logic              w_push;
    logic              w_drop;
    logic              w_wr1_en;
    logic              w_handshake;
    logic              w_last_word;
    logic              w_pop;
    logic [31:0]       w_hdr_word;

    // Tag decode: which slots carry records, their kind and indices.
    always_comb begin
        w_slot0_v = 1'b0;
        w_slot1_v = 1'b0;
        w_kind    = LABEL;
        w_idx0    = index0_t1;
        w_idx1    = index1_t1;
        if (tag_t1[2]) begin
            w_slot0_v = tag_t1[0];
            w_slot1_v = tag_t1[1];
            w_kind    = LABEL;
        end else begin
            case (tag_t1[1:0])
                2'b01: begin
                    w_slot0_v = 1'b1;
                    w_slot1_v = 1'b1;
                    w_kind    = KEY;
                    w_idx0    = {S{1'b0}};
                    w_idx1    = {{(S-1){1'b0}}, 1'b1};
                end
                2'b10: begin
                    w_slot0_v = 1'b1;
                    w_slot1_v = 1'b1;
                    w_kind    = TABLE;
                end
                2'b11: begin
                    w_slot0_v = 1'b1;
                    w_kind    = MASK;
                    w_idx0    = {S{1'b0}};
                end
                default: begin
                    w_slot0_v = 1'b0;
                    w_slot1_v = 1'b0;
                end
            endcase
        end
    end

    // Admission: all-or-nothing per cycle, free space measured before any pop.
    always_comb begin
        w_rec0    = '{kind: w_kind, cid: cid, index: w_idx0, data: data0_t1};
        w_rec1    = '{kind: w_kind, cid: cid, index: w_idx1, data: data1_t1};
        w_need    = {{(FCW-1){1'b0}}, w_slot0_v} + {{(FCW-1){1'b0}}, w_slot1_v};
        w_free    = DEPTH_CNT - w_fifo_count;
        w_capture = (r_ctl_state == CTL_RUN) && (cid != CID_END) && !start;
        w_push    = w_capture && (w_need != {FCW{1'b0}}) && (w_free >= w_need);
        w_drop    = w_capture && (w_free < w_need);
        w_wr1_en  = w_push && w_slot0_v && w_slot1_v;
        if (w_slot0_v) begin
            w_wr0_rec = w_rec0;
        end else begin
            w_wr0_rec = w_rec1;
        end
    end

    // Serializer pop decision and header formatting of the FIFO head.
    always_comb begin
        w_handshake = r_out_valid && host.out_ready;
        w_last_word = (r_ser_state == SER_DATA) && w_handshake && (r_word_cnt == CNT_LAST);
        w_hdr_word  = gc_build_header(w_rd_rec.kind, HDR_CID_W'(w_rd_rec.cid),
                                      HDR_IDX_W'(w_rd_rec.index));
        if (start) begin
            w_pop = 1'b0;
        end else begin
            w_pop = !w_fifo_empty && ((r_ser_state == SER_IDLE) || w_last_word);
        end
    end

    gc_dual_push_fifo #(
        .W     ($bits(gc_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (start),
        .wr0_en   (w_push),
        .wr0_data (w_wr0_rec),
        .wr1_en   (w_wr1_en),
        .wr1_data (w_rec1),
        .rd_en    (w_pop),
        .rd_data  (w_rd_rec),
        .empty    (w_fifo_empty),
        .count    (w_fifo_count)
    );

    // Control FSM: capture window, sticky overflow and completion flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl_state <= CTL_IDLE;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else if (start) begin
            r_ctl_state <= CTL_RUN;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_ctl_state)
                CTL_RUN: begin
                    if (cid == CID_END) begin
                        r_ctl_state <= CTL_DRAIN;
                    end
                end
                CTL_DRAIN: begin
                    if (w_fifo_empty && (r_ser_state == SER_IDLE)) begin
                        r_ctl_state <= CTL_DONE;
                        r_done      <= 1'b1;
                    end
                end
                CTL_IDLE: r_ctl_state <= CTL_IDLE;
                CTL_DONE: r_ctl_state <= CTL_DONE;
                default:  r_ctl_state <= CTL_IDLE;
            endcase
        end
    end

    // Serializer FSM: header, then data words MSW first, back-to-back records.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ser_state <= SER_IDLE;
            r_out_data  <= 32'h0000_0000;
            r_out_valid <= 1'b0;
            r_shift     <= {K{1'b0}};
            r_word_cnt  <= {CNT_W{1'b0}};
        end else if (start) begin
            r_ser_state <= SER_IDLE;
            r_out_valid <= 1'b0;
            r_word_cnt  <= {CNT_W{1'b0}};
        end else begin
            case (r_ser_state)
                SER_IDLE: begin
                    if (w_pop) begin
                        r_out_data  <= w_hdr_word;
                        r_out_valid <= 1'b1;
                        r_shift     <= w_rd_rec.data;
                        r_ser_state <= SER_HDR;
                    end
                end
                SER_HDR: begin
                    if (w_handshake) begin
                        r_out_data  <= r_shift[K-1 -: WORD_W];
                        r_shift     <= r_shift << WORD_W;
                        r_word_cnt  <= {CNT_W{1'b0}};
                        r_ser_state <= SER_DATA;
                    end
                end
                SER_DATA: begin
                    if (w_handshake) begin
                        if (r_word_cnt == CNT_LAST) begin
                            if (w_pop) begin
                                r_out_data  <= w_hdr_word;
                                r_out_valid <= 1'b1;
                                r_shift     <= w_rd_rec.data;
                                r_ser_state <= SER_HDR;
                            end else begin
                                r_out_valid <= 1'b0;
                                r_ser_state <= SER_IDLE;
                            end
                        end else begin
                            r_out_data <= r_shift[K-1 -: WORD_W];
                            r_shift    <= r_shift << WORD_W;
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_ser_state <= SER_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign host.out_data  = r_out_data;
    assign host.out_valid = r_out_valid;
    assign overflow       = r_overflow;
    assign done           = r_done;

endmodule

// File: tb/tb_gc_label_packer.sv
// Directed self-checking bench for gc_label_packer (K=128, DEPTH=4, CC=3).
module tb_gc_label_packer;
    localparam int S     = 12;
    localparam int K     = 128;
    localparam int CC    = 3;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   tag;
    logic [S-1:0] cid;
    logic [S-1:0] idx0;
    logic [S-1:0] idx1;
    logic [K-1:0] d0;
    logic [K-1:0] d1;
    logic         overflow;
    logic         done;
    int           n_checks = 0;
    int           n_errors = 0;

    gc_label_packer_if bus();

    gc_label_packer #(.S(S), .K(K), .CC(CC), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tag_t1    (tag),
        .cid       (cid),
        .index0_t1 (idx0),
        .index1_t1 (idx1),
        .data0_t1  (d0),
        .data1_t1  (d1),
        .host      (bus),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", name, obs, exp);
        end
    endtask

    // Wait (bounded) for a word, compare it, then let it be accepted.
    task automatic expect_word(input string name, input logic [31:0] exp, input int max_wait);
        int waited;
        waited = 0;
        while (!bus.out_valid && waited < max_wait) begin
            step();
            waited++;
        end
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk(name, bus.out_data, exp);
        step();
    endtask

    task automatic expect_rec(input string name, input logic [31:0] hdr,
                              input logic [K-1:0] data, input int hdr_wait);
        expect_word({name, "_hdr"}, hdr, hdr_wait);
        for (int i = 0; i < K / 32; i++) begin
            expect_word({name, "_dat"}, data[K-1-32*i -: 32], 0);
        end
    endtask

    task automatic push(input logic [2:0] t, input logic [S-1:0] c,
                        input logic [S-1:0] i0, input logic [S-1:0] i1,
                        input logic [K-1:0] a, input logic [K-1:0] b);
        tag = t; cid = c; idx0 = i0; idx1 = i1; d0 = a; d1 = b;
        step();
        tag = 3'b000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [K-1:0] mk(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {w, w, w, w};
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [K-1:0] dk0;
        logic [K-1:0] dk1;
        rst = 1'b1; start = 1'b0; tag = 3'b000; cid = '0;
        idx0 = '0; idx1 = '0; d0 = '0; d1 = '0;
        bus.out_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", bus.out_data, 32'h0000_0000);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        pulse_start();

        // 1: single label, header one edge after the write
        push(3'b101, 12'd0, 12'd5, 12'd0, {4{32'h1111_1111}}, '0);
        chk("t1_latency_idle", 32'(bus.out_valid), 32'd0);
        expect_rec("t1", 32'h0000_0005, {4{32'h1111_1111}}, 1);
        chk("t1_ovf", 32'(overflow), 32'd0);

        // 2: keys while the host stalls
        dk0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        dk1 = 128'hA0A0_A0A0_B1B1_B1B1_C2C2_C2C2_D3D3_D3D3;
        bus.out_ready = 1'b0;
        push(3'b001, 12'd0, 12'd9, 12'd9, dk0, dk1);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t2_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_stall_hdr", bus.out_data, 32'h4000_0000);
            step();
        end
        bus.out_ready = 1'b1;
        expect_rec("t2_k0", 32'h4000_0000, dk0, 0);
        expect_rec("t2_k1", 32'h4000_0001, dk1, 0);

        // 3: tables, slot0 first
        push(3'b010, 12'd2, 12'd6, 12'd7,
             128'h0000_0001_0000_0002_0000_0003_0000_0004,
             128'h0000_0005_0000_0006_0000_0007_0000_0008);
        expect_rec("t3_s0", 32'h8002_0006, 128'h0000_0001_0000_0002_0000_0003_0000_0004, 1);
        expect_rec("t3_s1", 32'h8002_0007, 128'h0000_0005_0000_0006_0000_0007_0000_0008, 0);

        // 4: overflow with a stalled host, third cycle dropped whole
        bus.out_ready = 1'b0;
        push(3'b111, 12'd2, 12'd8, 12'd9, mk(8), mk(9));
        push(3'b111, 12'd2, 12'd10, 12'd11, mk(10), mk(11));
        chk("t4_ovf_full_ok", 32'(overflow), 32'd0);
        push(3'b111, 12'd2, 12'd12, 12'd13, mk(12), mk(13));
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        chk("t4_hdr_held", bus.out_data, 32'h0002_0008);
        bus.out_ready = 1'b1;
        expect_rec("t4_r8", 32'h0002_0008, mk(8), 0);
        expect_rec("t4_r9", 32'h0002_0009, mk(9), 0);
        expect_rec("t4_r10", 32'h0002_000A, mk(10), 0);
        expect_rec("t4_r11", 32'h0002_000B, mk(11), 0);
        chk("t4_no_fifth", 32'(bus.out_valid), 32'd0);

        // 5: mask, then cid==CC ends capture and is ignored
        push(3'b011, 12'd2, 12'd7, 12'd7, {4{32'h4D4D_0000}}, '0);
        push(3'b111, 12'd3, 12'd20, 12'd21, mk(20), mk(21));
        cid = 12'd0;
        expect_rec("t5_mask", 32'hC002_0000, {4{32'h4D4D_0000}}, 0);
        chk("t5_done_not_yet", 32'(done), 32'd0);
        step();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_ignored", 32'(bus.out_valid), 32'd0);
        chk("t5_ovf_sticky", 32'(overflow), 32'd1);

        // 6a: asynchronous reset mid-serialisation
        pulse_start();
        chk("t6_start_done", 32'(done), 32'd0);
        chk("t6_start_ovf", 32'(overflow), 32'd0);
        push(3'b101, 12'd0, 12'd1, 12'd0, mk(1), '0);
        step(); step();
        chk("t6_mid_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_data", bus.out_data, 32'h0000_0000);
        #1;
        rst = 1'b0;
        step();

        // 6b: start while draining a full FIFO
        cid = 12'd1;
        pulse_start();
        bus.out_ready = 1'b0;
        push(3'b111, 12'd1, 12'd8, 12'd9, mk(8), mk(9));
        push(3'b111, 12'd1, 12'd10, 12'd11, mk(10), mk(11));
        push(3'b111, 12'd1, 12'd12, 12'd13, mk(12), mk(13));
        push(3'b000, 12'd3, 12'd0, 12'd0, '0, '0);
        chk("t6_drain_ovf", 32'(overflow), 32'd1);
        cid = 12'd1;
        pulse_start();
        chk("t6_abort_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_clr_ovf", 32'(overflow), 32'd0);
        chk("t6_clr_done", 32'(done), 32'd0);
        bus.out_ready = 1'b1;
        step(); step(); step();
        chk("t6_flushed", 32'(bus.out_valid), 32'd0);
        push(3'b110, 12'd1, 12'd0, 12'd63, '0, mk(63));
        expect_rec("t6_slot1", 32'h0001_003F, mk(63), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
